// File: rtl/alu_74181_serial.sv
// Nibble-serial 74181 ALU: one 4-bit slice reused LSB-first, carry held between nibbles.
// Result, carry-out, A=B and zero flags are committed together when the last nibble finishes.

module alu_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       aeqb
);
  logic [3:0] e, d;
  logic       c0, c1, c2, c3, c4;

  // Active-high data form: ~e is the bit generate, ~d the bit propagate.
  assign d = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
  assign e = ~((a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}}));

  assign c0 = ~cn;
  assign c1 = ~e[0] | (~d[0] & c0);
  assign c2 = ~e[1] | (~d[1] & c1);
  assign c3 = ~e[2] | (~d[2] & c2);
  assign c4 = ~e[3] | (~d[3] & c3);

  assign f    = e ^ d ^ ({4{m}} | {c3, c2, c1, c0});
  assign cn4  = ~c4;
  assign aeqb = &f;
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | processing nibble cnt
// DONE  | result committed, done pulse, may accept next start
module alu_74181_serial #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = $clog2(NIBBLES) + 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ena,
  input  logic                   start,
  input  logic                   acc,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic [3:0]             s,
  input  logic                   m,
  input  logic                   cn,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   f,
  output logic                   cn_out,
  output logic                   equal,
  output logic                   zero
);
  localparam int W = 4 * NIBBLES;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [W-1:0]     op_a, op_b, shadow, shadow_nx;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry;
  logic             eq_acc;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nib_a, nib_b, nib_f;
  logic             nib_cn4, nib_eq;

  always_comb begin
    nib_a     = '0;
    nib_b     = '0;
    shadow_nx = shadow;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CNT_W'(i)) begin
        nib_a                = op_a[4*i +: 4];
        nib_b                = op_b[4*i +: 4];
        shadow_nx[4*i +: 4]  = nib_f;
      end
    end
  end

  alu_74181 u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .s    (s_q),
    .m    (m_q),
    .cn   (carry),
    .f    (nib_f),
    .cn4  (nib_cn4),
    .aeqb (nib_eq)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      shadow <= '0;
      s_q    <= '0;
      m_q    <= 1'b0;
      carry  <= 1'b0;
      eq_acc <= 1'b0;
      cnt    <= '0;
      f      <= '0;
      cn_out <= 1'b1;
      equal  <= 1'b0;
      zero   <= 1'b1;
    end else if (ena) begin
      if (state == RUN) begin
        shadow <= shadow_nx;
        carry  <= nib_cn4;
        eq_acc <= eq_acc & nib_eq;
        if (cnt == LAST) begin
          // Commit on the way into DONE so the new f is visible during the done pulse.
          state  <= DONE;
          f      <= shadow_nx;
          cn_out <= nib_cn4;
          equal  <= eq_acc & nib_eq;
          zero   <= (shadow_nx == '0);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (start) begin
        op_a   <= acc ? f : a;
        op_b   <= b;
        s_q    <= s;
        m_q    <= m;
        carry  <= cn;
        eq_acc <= 1'b1;
        cnt    <= '0;
        state  <= RUN;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_74181_serial.sv
// Directed checks on a 4-nibble build plus model-compared sweeps on 1- and 6-nibble builds.

module tb_alu_74181_serial;
  logic        clk = 1'b0;
  logic        rstb, ena, acc, m, cn;
  logic        start4, start1, start6;
  logic [3:0]  s;
  logic [15:0] a4, b4, f4;
  logic [3:0]  a1, b1, f1;
  logic [23:0] a6, b6, f6;
  logic        busy4, done4, co4, eq4, z4;
  logic        busy1, done1, co1, eq1, z1;
  logic        busy6, done6, co6, eq6, z6;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  always #5 clk = ~clk;

  alu_74181_serial #(.NIBBLES(4)) dut4 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start4), .acc(acc), .a(a4), .b(b4),
    .s(s), .m(m), .cn(cn), .busy(busy4), .done(done4), .f(f4), .cn_out(co4),
    .equal(eq4), .zero(z4));

  alu_74181_serial #(.NIBBLES(1)) dut1 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start1), .acc(acc), .a(a1), .b(b1),
    .s(s), .m(m), .cn(cn), .busy(busy1), .done(done1), .f(f1), .cn_out(co1),
    .equal(eq1), .zero(z1));

  alu_74181_serial #(.NIBBLES(6)) dut6 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start6), .acc(acc), .a(a6), .b(b6),
    .s(s), .m(m), .cn(cn), .busy(busy6), .done(done6), .f(f6), .cn_out(co6),
    .equal(eq6), .zero(z6));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on the 4-nibble unit and wait for done; lat counts cycles from start.
  task automatic run4(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is,
                      input logic im, input logic icn, input logic iacc,
                      output int lat, output int bcnt);
    a4 = ia; b4 = ib; s = is; m = im; cn = icn; acc = iacc;
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done4 && lat < 40) begin
      if (busy4) bcnt++;
      cyc();
      lat++;
    end
  endtask

  // Word-level 74181 reference: result = propagate + generate + carry-in.
  function automatic void ref_model(input logic [23:0] ia, input logic [23:0] ib,
                                    input logic [3:0] is, input logic im, input logic icn,
                                    input int w, output logic [23:0] rf,
                                    output logic rco, output logic req);
    logic [24:0] mask, p, g, sum, xa, xb;
    xa   = {1'b0, ia};
    xb   = {1'b0, ib};
    mask = (25'd1 << w) - 25'd1;
    p    = (xa | (xb & {25{is[0]}}) | (~xb & {25{is[1]}})) & mask;
    g    = ((xa & xb & {25{is[3]}}) | (xa & ~xb & {25{is[2]}})) & mask;
    sum  = p + g + {24'b0, ~icn};
    rco  = ~sum[w];
    rf   = im ? 24'(~(p ^ g) & mask) : 24'(sum & mask);
    req  = (rf == 24'(mask));
  endfunction

  task automatic test_reset();
    rstb = 1'b0; ena = 1'b1; acc = 1'b0; m = 1'b0; cn = 1'b1; s = 4'h0;
    start4 = 1'b0; start1 = 1'b0; start6 = 1'b0;
    a4 = '0; b4 = '0; a1 = '0; b1 = '0; a6 = '0; b6 = '0;
    repeat (2) cyc();
    chk_cnt++; if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy4); else pass_cnt++;
    chk_cnt++; if (done4 !== 1'b0) $display("FAIL reset_done: got %b want 0", done4); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h0000) $display("FAIL reset_f: got %h want 0000", f4); else pass_cnt++;
    chk_cnt++; if (co4 !== 1'b1) $display("FAIL reset_cn_out: got %b want 1", co4); else pass_cnt++;
    chk_cnt++; if (eq4 !== 1'b0) $display("FAIL reset_equal: got %b want 0", eq4); else pass_cnt++;
    chk_cnt++; if (z4 !== 1'b1) $display("FAIL reset_zero: got %b want 1", z4); else pass_cnt++;
    rstb = 1'b1;
    cyc();
  endtask

  task automatic test_add();
    int lat, bcnt;
    run4(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, 1'b0, lat, bcnt);
    chk_cnt++; if (lat !== 5) $display("FAIL add_latency: got %0d want 5", lat); else pass_cnt++;
    chk_cnt++; if (bcnt !== 4) $display("FAIL add_busy_cycles: got %0d want 4", bcnt); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h5555) $display("FAIL add_f: got %h want 5555", f4); else pass_cnt++;
    chk_cnt++; if (co4 !== 1'b1) $display("FAIL add_cn_out: got %b want 1", co4); else pass_cnt++;
    chk_cnt++; if (z4 !== 1'b0) $display("FAIL add_zero: got %b want 0", z4); else pass_cnt++;
    cyc();
    chk_cnt++; if (done4 !== 1'b0) $display("FAIL add_done_width: got %b want 0", done4); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h5555) $display("FAIL add_f_hold: got %h want 5555", f4); else pass_cnt++;
  endtask

  task automatic test_carry();
    int lat, bcnt;
    run4(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat, bcnt);
    chk_cnt++; if (f4 !== 16'h0000) $display("FAIL carry_f: got %h want 0000", f4); else pass_cnt++;
    chk_cnt++; if (co4 !== 1'b0) $display("FAIL carry_cn_out: got %b want 0", co4); else pass_cnt++;
    chk_cnt++; if (z4 !== 1'b1) $display("FAIL carry_zero: got %b want 1", z4); else pass_cnt++;
    cyc();
  endtask

  task automatic test_equal();
    int lat, bcnt;
    run4(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b1, 1'b0, lat, bcnt);
    chk_cnt++; if (f4 !== 16'hFFFF) $display("FAIL eq_f: got %h want ffff", f4); else pass_cnt++;
    chk_cnt++; if (eq4 !== 1'b1) $display("FAIL eq_equal: got %b want 1", eq4); else pass_cnt++;
    chk_cnt++; if (co4 !== 1'b1) $display("FAIL eq_cn_out: got %b want 1", co4); else pass_cnt++;
    cyc();
    run4(16'h3C3C, 16'h3C3D, 4'b0110, 1'b0, 1'b1, 1'b0, lat, bcnt);
    chk_cnt++; if (f4 !== 16'hFFFE) $display("FAIL neq_f: got %h want fffe", f4); else pass_cnt++;
    chk_cnt++; if (eq4 !== 1'b0) $display("FAIL neq_equal: got %b want 0", eq4); else pass_cnt++;
    cyc();
    run4(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b0, lat, bcnt);
    chk_cnt++; if (f4 !== 16'h0FF0) $display("FAIL logic_xor_f: got %h want 0ff0", f4); else pass_cnt++;
    chk_cnt++; if (z4 !== 1'b0) $display("FAIL logic_xor_zero: got %b want 0", z4); else pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, extra;
    run4(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat, bcnt);
    chk_cnt++; if (f4 !== 16'h0002) $display("FAIL acc_first_f: got %h want 0002", f4); else pass_cnt++;
    // still in the DONE cycle: chain straight into the next operation
    a4 = 16'hAAAA; b4 = 16'h0003; acc = 1'b1; start4 = 1'b1;
    cyc();
    start4 = 1'b0; acc = 1'b0; lat = 1;
    cyc();
    lat = 2;
    a4 = 16'h0100; b4 = 16'h0100; start4 = 1'b1;
    cyc();
    start4 = 1'b0; lat = 3;
    while (!done4 && lat < 40) begin cyc(); lat++; end
    chk_cnt++; if (lat !== 5) $display("FAIL acc_latency: got %0d want 5", lat); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h0005) $display("FAIL acc_chain_f: got %h want 0005", f4); else pass_cnt++;
    extra = 0;
    repeat (8) begin cyc(); if (done4) extra++; end
    chk_cnt++; if (extra !== 0) $display("FAIL busy_start_ignored: got %0d extra done want 0", extra); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h0005) $display("FAIL acc_hold_f: got %h want 0005", f4); else pass_cnt++;
  endtask

  task automatic test_ena_stall();
    int lat;
    a4 = 16'h0F0F; b4 = 16'h0101; s = 4'b1001; m = 1'b0; cn = 1'b1; acc = 1'b0;
    start4 = 1'b1;
    cyc();
    start4 = 1'b0; lat = 1;
    ena = 1'b0;
    repeat (3) begin cyc(); lat++; end
    chk_cnt++; if (busy4 !== 1'b1) $display("FAIL stall_busy: got %b want 1", busy4); else pass_cnt++;
    ena = 1'b1;
    while (!done4 && lat < 40) begin cyc(); lat++; end
    chk_cnt++; if (lat !== 8) $display("FAIL stall_latency: got %0d want 8", lat); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h1010) $display("FAIL stall_f: got %h want 1010", f4); else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_abort();
    int pulses;
    a4 = 16'h0003; b4 = 16'h0004; s = 4'b1001; m = 1'b0; cn = 1'b1; acc = 1'b0;
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    cyc();
    rstb = 1'b0;
    #1;
    chk_cnt++; if (busy4 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy4); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h0000) $display("FAIL abort_f: got %h want 0000", f4); else pass_cnt++;
    cyc();
    rstb = 1'b1;
    pulses = 0;
    repeat (8) begin cyc(); if (done4) pulses++; end
    chk_cnt++; if (pulses !== 0) $display("FAIL abort_done: got %0d pulses want 0", pulses); else pass_cnt++;
    chk_cnt++; if (f4 !== 16'h0000) $display("FAIL abort_f_hold: got %h want 0000", f4); else pass_cnt++;
  endtask

  task automatic test_random(input int nib);
    logic [31:0] ra, rb;
    logic [23:0] ef, gf;
    logic        eco, eeq, gco, geq, gdone;
    int          lat;
    for (int it = 0; it < 200; it++) begin
      ra = $urandom; rb = $urandom;
      s  = 4'($urandom_range(15, 0));
      m  = 1'($urandom_range(1, 0));
      cn = 1'($urandom_range(1, 0));
      acc = 1'b0;
      if (nib == 1) begin a1 = ra[3:0]; b1 = rb[3:0]; start1 = 1'b1; end
      else begin a6 = ra[23:0]; b6 = rb[23:0]; start6 = 1'b1; end
      cyc();
      start1 = 1'b0; start6 = 1'b0; lat = 1;
      gdone = (nib == 1) ? done1 : done6;
      while (!gdone && lat < 40) begin
        cyc(); lat++;
        gdone = (nib == 1) ? done1 : done6;
      end
      if (nib == 1) begin
        ref_model({20'b0, ra[3:0]}, {20'b0, rb[3:0]}, s, m, cn, 4, ef, eco, eeq);
        gf = {20'b0, f1}; gco = co1; geq = eq1;
      end else begin
        ref_model(ra[23:0], rb[23:0], s, m, cn, 24, ef, eco, eeq);
        gf = f6; gco = co6; geq = eq6;
      end
      chk_cnt++; if (lat !== nib + 1) $display("FAIL rnd%0d_latency it%0d: got %0d want %0d", nib, it, lat, nib + 1); else pass_cnt++;
      chk_cnt++; if (gf !== ef) $display("FAIL rnd%0d_f it%0d s=%h m=%b: got %h want %h", nib, it, s, m, gf, ef); else pass_cnt++;
      chk_cnt++; if (gco !== eco) $display("FAIL rnd%0d_cn_out it%0d: got %b want %b", nib, it, gco, eco); else pass_cnt++;
      chk_cnt++; if (geq !== eeq) $display("FAIL rnd%0d_equal it%0d: got %b want %b", nib, it, geq, eeq); else pass_cnt++;
      cyc();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_equal();
    test_back_to_back();
    test_ena_stall();
    test_reset_abort();
    test_random(1);
    test_random(6);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
